// File: rtl/regfile_multiport.sv
// Multiport register file: combinational reads, writes commit on the rising edge, scrub FSM clears the array.
// No backpressure: user writes are dropped while Busy. Optional REGFILE_BYPASS_EN forwards same-cycle writes to reads.
module regfile_multiport #(
  parameter int               WIDTH       = 32,
  parameter int               DEPTH       = 32,
  parameter int               ADDR_W      = 5,
  parameter int               NUM_READ    = 2,
  parameter int               ZERO_REG    = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic [NUM_READ*ADDR_W-1:0]   ReadRegister,
  output logic [NUM_READ*WIDTH-1:0]    ReadData,
  input  logic [ADDR_W-1:0]            WriteRegister0,
  input  logic [WIDTH-1:0]             WriteData0,
  input  logic                         RegWrite0,
  input  logic [ADDR_W-1:0]            WriteRegister1,
  input  logic [WIDTH-1:0]             WriteData1,
  input  logic                         RegWrite1,
  input  logic                         Clear,
  output logic                         Busy,
  output logic                         WriteCollision
);

  typedef enum logic {IDLE, SCRUB} state_t;

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH-1);

  // An address is writable/readable if it exists and is not the hardwired zero register.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_C) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  logic [WIDTH-1:0]  regs_q [DEPTH];
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              coll_q, coll_d;
  logic              wr0_en, wr1_en, scrub_en;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    coll_d   = 1'b0;
    wr0_en   = 1'b0;
    wr1_en   = 1'b0;
    scrub_en = 1'b0;
    case (state_q)
      IDLE: begin
        wr0_en = RegWrite0 && addr_ok(WriteRegister0);
        wr1_en = RegWrite1 && addr_ok(WriteRegister1);
        // Collision is flagged on raw addresses, even when the target is illegal.
        coll_d = RegWrite0 && RegWrite1 && (WriteRegister0 == WriteRegister1);
        if (Clear) begin
          state_d = SCRUB;
          cnt_d   = '0;
        end
      end
      SCRUB: begin
        scrub_en = 1'b1;
        if (cnt_q == LAST_C) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      coll_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      coll_q  <= coll_d;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= RESET_VALUE;
      end
    end else if (scrub_en) begin
      regs_q[cnt_q] <= RESET_VALUE;
    end else begin
      // Port 1 is assigned last so it wins a same-address collision.
      if (wr0_en) regs_q[WriteRegister0] <= WriteData0;
      if (wr1_en) regs_q[WriteRegister1] <= WriteData1;
    end
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [ADDR_W-1:0] rd_addr;
    logic [WIDTH-1:0]  rd_dat;

    assign rd_addr = ReadRegister[k*ADDR_W +: ADDR_W];

    always_comb begin
      rd_dat = '0;
      if (addr_ok(rd_addr)) begin
        rd_dat = regs_q[rd_addr];
`ifdef REGFILE_BYPASS_EN
        // Write enables are only live in IDLE, so no forwarding happens during scrub.
        if (wr0_en && (WriteRegister0 == rd_addr)) rd_dat = WriteData0;
        if (wr1_en && (WriteRegister1 == rd_addr)) rd_dat = WriteData1;
`endif
      end
    end

    assign ReadData[k*WIDTH +: WIDTH] = rd_dat;
  end

  assign Busy           = (state_q == SCRUB);
  assign WriteCollision = coll_q;

endmodule

// File: tb/tb_regfile_multiport.sv
// Self-checking bench for regfile_multiport: directed scenarios then random traffic against an array model.
module tb_regfile_multiport;
  localparam int W  = 32;
  localparam int D  = 32;
  localparam int AW = 5;

  logic          Clk = 1'b0;
  logic          Reset;
  logic [AW-1:0] ra0, ra1;
  logic [2*AW-1:0] ReadRegister;
  logic [2*W-1:0]  ReadData;
  logic [AW-1:0] wa0, wa1;
  logic [W-1:0]  wd0, wd1;
  logic          we0, we1, clr;
  logic          Busy, WriteCollision;

  assign ReadRegister = {ra1, ra0};

  always #5 Clk = ~Clk;

  regfile_multiport dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .ReadRegister   (ReadRegister),
    .ReadData       (ReadData),
    .WriteRegister0 (wa0),
    .WriteData0     (wd0),
    .RegWrite0      (we0),
    .WriteRegister1 (wa1),
    .WriteData1     (wd1),
    .RegWrite1      (we1),
    .Clear          (clr),
    .Busy           (Busy),
    .WriteCollision (WriteCollision)
  );

  // Reference model: plain array plus scrub progress counter.
  logic [W-1:0] mem [D];
  bit           busy_m, coll_m;
  int           scrub_idx;
  int           n_checks, n_errors;
  int           bcnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] exp_read(input logic [AW-1:0] a);
    if (a == '0 || int'(a) >= D) return '0;
`ifdef REGFILE_BYPASS_EN
    if (!busy_m) begin
      if (we1 && wa1 == a) return wd1;
      if (we0 && wa0 == a) return wd0;
    end
`endif
    return mem[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < D; i++) mem[i] = '0;
    busy_m    = 1'b0;
    coll_m    = 1'b0;
    scrub_idx = 0;
  endtask

  task automatic model_edge();
    if (Reset) begin
      model_reset();
    end else if (busy_m) begin
      mem[scrub_idx] = '0;
      scrub_idx++;
      if (scrub_idx == D) begin
        busy_m    = 1'b0;
        scrub_idx = 0;
      end
      coll_m = 1'b0;
    end else begin
      coll_m = we0 && we1 && (wa0 == wa1);
      if (we0 && wa0 != '0) mem[wa0] = wd0;
      if (we1 && wa1 != '0) mem[wa1] = wd1;
      if (clr) begin
        busy_m    = 1'b1;
        scrub_idx = 0;
      end
    end
  endtask

  task automatic check_outs();
    chk("rd0",  ReadData[W-1:0],   exp_read(ra0));
    chk("rd1",  ReadData[2*W-1:W], exp_read(ra1));
    chk("busy", Busy,              busy_m);
    chk("coll", WriteCollision,    coll_m);
  endtask

  // Inputs change at posedge+1; outputs are checked on the falling edge.
  task automatic step();
    @(negedge Clk);
    check_outs();
    @(posedge Clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    we0 = 1'b0;
    we1 = 1'b0;
    clr = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    Reset = 1'b1;
    idle_inputs();
    ra0 = '0; ra1 = AW'(7);
    wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
    model_reset();
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b0;

    // Reset state
    step();
    ra0 = AW'(31); ra1 = AW'(31);
    step();

    // Basic write/read and same-cycle read of a write
    we0 = 1'b1; wa0 = AW'(31); wd0 = 32'hDEADBEEF;
    step();
    we0 = 1'b0; ra1 = AW'(31);
    #1;
    chk("t2_a31", ReadData[2*W-1:W], 32'hDEADBEEF);
    we0 = 1'b1; wa0 = AW'(16); wd0 = 32'hDEADDAD5; ra0 = AW'(16);
    step();
    we0 = 1'b0;
    step();
    chk("t2_a16", ReadData[W-1:0], 32'hDEADDAD5);

    // Same-address collision, then distinct addresses
    we0 = 1'b1; we1 = 1'b1; wa0 = AW'(5); wa1 = AW'(5);
    wd0 = 32'h11111111; wd1 = 32'h22222222; ra0 = AW'(5); ra1 = AW'(6);
    step();
    idle_inputs();
    chk("t3_coll", WriteCollision, 1'b1);
    chk("t3_a5", ReadData[W-1:0], 32'h22222222);
    step();
    chk("t3_coll_clr", WriteCollision, 1'b0);
    we0 = 1'b1; we1 = 1'b1; wa0 = AW'(5); wa1 = AW'(6);
    wd0 = 32'h11111111; wd1 = 32'h22222222;
    step();
    idle_inputs();
    chk("t3_nocoll", WriteCollision, 1'b0);
    chk("t3b_a5", ReadData[W-1:0], 32'h11111111);
    chk("t3b_a6", ReadData[2*W-1:W], 32'h22222222);
    step();

    // Zero register ignores writes, including the forwarding path
    we0 = 1'b1; wa0 = '0; wd0 = 32'hFFFFFFFF; ra0 = '0;
    step();
    idle_inputs();
    step();
    chk("t4_r0", ReadData[W-1:0], 32'h0);

    // Fill, then scrub
    for (int i = 1; i < D; i++) begin
      we0 = 1'b1; wa0 = AW'(i); wd0 = W'(i);
      step();
    end
    idle_inputs();
    clr = 1'b1;
    step();
    clr = 1'b0;
    ra0 = AW'(31); ra1 = AW'(0);
    bcnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (Busy) bcnt++;
      we0 = (c == 2); wa0 = AW'(3); wd0 = 32'h0000ABCD;
      if (c == 16) begin
        chk("t5_mid_a31", ReadData[W-1:0], 32'd31);
        chk("t5_mid_a0", ReadData[2*W-1:W], 32'd0);
      end
      step();
    end
    chk("t5_busy_cycles", bcnt, 32);
    for (int i = 0; i < D; i++) begin
      ra0 = AW'(i);
      #1;
      chk("t5_cleared", ReadData[W-1:0], 32'd0);
    end

    // Reset in the middle of a scrub
    we0 = 1'b1; wa0 = AW'(31); wd0 = 32'h31;
    step();
    we0 = 1'b0; clr = 1'b1; ra0 = AW'(31);
    step();
    clr = 1'b0;
    repeat (10) step();
    #1;
    Reset = 1'b1;
    #1;
    chk("t6_busy_async", Busy, 1'b0);
    chk("t6_a31_async", ReadData[W-1:0], 32'd0);
    model_reset();
    step();
    Reset = 1'b0;
    we0 = 1'b1; wa0 = AW'(2); wd0 = 32'h12345678; ra0 = AW'(2);
    step();
    we0 = 1'b0;
    step();
    chk("t6_a2", ReadData[W-1:0], 32'h12345678);

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      ra0 = AW'($urandom_range(0, D-1));
      ra1 = AW'($urandom_range(0, D-1));
      we0 = ($urandom_range(0, 2) != 0);
      we1 = ($urandom_range(0, 2) != 0);
      wa0 = AW'($urandom_range(0, D-1));
      wa1 = ($urandom_range(0, 3) == 0) ? wa0 : AW'($urandom_range(0, D-1));
      wd0 = $urandom;
      wd1 = $urandom;
      clr = ($urandom_range(0, 79) == 0);
      step();
    end
    idle_inputs();
    repeat (40) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
